// File: rtl/bin_to_bcd_seq_if.sv
// Avalon-MM write/read slave bundle for the binary-to-BCD converter.
// The master drives the strobes and data, and the slave returns readdata.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W = 16
);
  logic             write;
  logic [BIN_W-1:0] writedata;
  logic             read;
  logic [31:0]      readdata;

  modport master (output write, output writedata, output read, input readdata);
  modport slave  (input write, input writedata, input read, output readdata);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with an Avalon-MM slave front end.
// The converter shifts one bit per clock and publishes packed BCD digits with a one-cycle strobe.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  bin_to_bcd_seq_if.slave       bus,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  digit_write,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  if (BIN_W < 4 || BIN_W > 20) begin : g_bad_bin_w
    $error("bin_to_bcd_seq: BIN_W must be in 4..20");
  end
  if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end
  if (BCD_W > 30) begin : g_bad_readdata
    $error("bin_to_bcd_seq: BCD result does not fit below the status bits");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               overrun_q, overrun_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         digit;
  logic               accept;
  logic [31:0]        readdata;

  // Add-3 correction applied to every digit before the shift.
  always_comb begin
    bcd_adj = '0;
    digit   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = bcd_sr_q[4*k +: 4];
      bcd_adj[4*k +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end
  end

  assign accept = bus.write && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    bcd_sr_d  = bcd_sr_q;
    count_d   = count_q;
    bcd_out_d = bcd_out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          bin_sr_d = bus.writedata;
          bcd_sr_d = '0;
          count_d  = CNT_W'(BIN_W);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bcd_sr_d = {bcd_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
        bin_sr_d = {bin_sr_q[BIN_W-2:0], 1'b0};
        count_d  = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d   = DONE;
          bcd_out_d = {bcd_adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write landing mid-conversion beats a same-cycle read clear.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.read) overrun_d = 1'b0;
    if (bus.write && state_q == SHIFT) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      bcd_sr_q  <= '0;
      count_q   <= '0;
      bcd_out_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      bcd_sr_q  <= bcd_sr_d;
      count_q   <= count_d;
      bcd_out_q <= bcd_out_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    readdata            = '0;
    readdata[BCD_W-1:0] = bcd_out_q;
    readdata[30]        = overrun_q;
    readdata[31]        = (state_q == SHIFT);
  end

  assign bus.readdata = readdata;
  assign bcd_out      = bcd_out_q;
  assign digit_write  = (state_q == DONE);
  assign busy         = (state_q == SHIFT);

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Avalon-MM write slave. Takes a BIN_W-bit unsigned binary value and converts it to DIGITS packed BCD digits.
- Conversion is sequential shift-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the per-digit seven-segment decoder slaves. Each 4-bit slice of bcd_out plus the digit_write strobe drives one decoder's writedata/write pair.
- Status and result are readable over the same slave interface.

Parameters:
- BIN_W, 16, width of binary input. Legal range 4..20.
- DIGITS, 5, number of BCD digits produced. Must satisfy 10^DIGITS > 2^BIN_W-1, checked at elaboration.

Ports:
- clk  input  1  system clock. All state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. Asserts immediately; deasserts synchronously to clk upstream.
- write  input  1  Avalon write strobe, one cycle per transfer.
- writedata  input  BIN_W  binary value to convert.
- read  input  1  Avalon read strobe.
- readdata  output  32  status/result word, zero read latency (combinational from registers).
- bcd_out  output  4*DIGITS  last completed result. Digit k is at [4k+3:4k]; digit 0 is the least significant.
- digit_write  output  1  one-cycle pulse, asserted when bcd_out updates.
- busy  output  1  high while a conversion is shifting.

Behaviour:
- Reset (reset=0): state=IDLE; bcd_out=0; digit_write=0; busy=0; overrun=0; shift and count registers cleared. An in-flight conversion is aborted with no digit_write.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - write=1 latches writedata into bin_sr, clears bcd_sr (4*DIGITS bits), sets count=BIN_W, and moves to SHIFT.
  - write=0 stays in IDLE.
- SHIFT, each cycle:
  - In every bcd_sr digit >= 5, add 3 to that digit (4-bit add, no carry between digits).
  - Shift {bcd_sr, bin_sr} left by 1, with bin_sr MSB entering bcd_sr bit 0.
  - Decrement count. When count reaches 0 after this cycle's shift, go to DONE.
  - busy=1 throughout SHIFT.
- DONE (exactly one cycle):
  - bcd_out <= bcd_sr at the DONE-entry edge. digit_write=1 during DONE; busy=0.
  - Next state is IDLE, unless write=1 in the DONE cycle. In that case the write is accepted as in IDLE and the next state is SHIFT (back-to-back conversion).
- Latency: a write accepted at edge 0 gives bcd_out valid and digit_write high in the cycle after edge BIN_W (BIN_W+1 cycles including the accept).
- A write during SHIFT is ignored, conversion is unaffected, and sticky overrun is set.
- overrun is cleared on the edge after a cycle with read=1. If the set and clear occur in the same cycle, set wins.
- readdata layout:
  - [4*DIGITS-1:0] = bcd_out.
  - [30] = overrun.
  - [31] = busy.
  - All other bits 0.
  - read has no side effect other than clearing overrun.
- bcd_out holds its value between conversions. Downstream decoders must see each digit as a value in 0..9 only; this holds by construction.
- digit_write is never asserted outside DONE. It is never asserted twice without an intervening conversion.

Test Plan:
- After reset release, write writedata=1234 -> busy=1 for 16 cycles; digit_write pulses in cycle 17; bcd_out=0x01234; readdata=0x00001234.
- Write 65535 -> bcd_out=0x65535. Write 0 -> bcd_out=0x00000 with digit_write still pulsing once.
- Write 9, then write 42 in the third SHIFT cycle -> second write ignored; bcd_out=0x00009; readdata[30]=1. A read clears overrun: a read on the next cycle returns readdata[30]=0.
- Write 500, then write 777 exactly in the DONE cycle -> bcd_out=0x00500 with digit_write; then bcd_out=0x00777 17 cycles later; overrun stays 0.
- Write 4321, assert reset for 1 cycle at SHIFT cycle 8 -> bcd_out=0, busy=0, no digit_write; a fresh write of 88 completes to 0x00088.
- Same-cycle write-during-busy and read -> overrun reads 1 afterwards (set wins).
